// File: rtl/spi_cfg_regbank_pkg.sv
// Shared definitions for the SPI configuration register bank: FSM states,
// RW bit encoding and the default FM datapath register map.
package spi_cfg_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA
  } spi_state_e;

  localparam logic RW_READ = 1'b1;

  localparam int unsigned REG_ACC_INC   = 0;
  localparam int unsigned REG_DF_INC    = 1;
  localparam int unsigned REG_DAC_ENA   = 2;
  localparam int unsigned REG_DITH_FACT = 3;
  localparam int unsigned REG_FLAGS     = 4;

endpackage

// File: rtl/spi_cfg_regbank_sync_edge.sv
// 2-FF synchroniser for an asynchronous input with single-cycle rise/fall
// pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_cfg_regbank.sv
// Addressed SPI (mode 0) configuration register bank with staged writes committed on CSn rise.
// Optional macro SPI_CFG_AUTOINC_EN enables address auto-increment across data words.
module spi_cfg_regbank
  import spi_cfg_regbank_pkg::*;
#(
  parameter int unsigned                ADDR_W   = 3,
  parameter int unsigned                DATA_W   = 8,
  parameter int unsigned                NUM_REGS = 6,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spi_clk,
  input  logic                         spi_csn,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_flat,
  output logic                         cfg_update,
  output logic                         frame_err
);

  localparam int unsigned CNT_W = $clog2((DATA_W > ADDR_W) ? DATA_W : ADDR_W);

  logic sck_rise, sck_fall, csn_rise, csn_fall;
  logic mosi_s1_q, mosi_s2_q;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d_i(spi_clk), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst_n(rst_n), .d_i(spi_csn), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-2:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                miso_q, miso_d;
  logic                words_q, words_d;
  logic                edge_q, edge_d;
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic                update_q, update_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   staging_q [NUM_REGS];
  logic [DATA_W-1:0]   staging_d [NUM_REGS];
  logic [DATA_W-1:0]   cfg_q     [NUM_REGS];
  logic [DATA_W-1:0]   cfg_d     [NUM_REGS];

  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] addr_new;
  logic [DATA_W-1:0] rd_new;
  logic              wr_ok;

  assign word     = {rx_q, mosi_s2_q};
  assign addr_new = {addr_q[ADDR_W-2:0], mosi_s2_q};
  assign rd_new   = (32'(addr_new) < NUM_REGS) ? cfg_q[addr_new] : '0;

`ifdef SPI_CFG_AUTOINC_EN
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] rd_inc;
  assign addr_inc = addr_q + 1'b1;
  assign rd_inc   = (32'(addr_inc) < NUM_REGS) ? cfg_q[addr_inc] : '0;
  assign wr_ok    = 1'b1;
`else
  assign wr_ok    = ~words_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    words_d   = words_q;
    edge_d    = edge_q;
    dirty_d   = dirty_q;
    staging_d = staging_q;
    cfg_d     = cfg_q;
    update_d  = 1'b0;
    err_d     = 1'b0;

    if (csn_rise) begin
      state_d = ST_IDLE;
      miso_d  = 1'b0;
      dirty_d = '0;
      if (state_q == ST_DATA && cnt_q == '0 && words_q) begin
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
          if (dirty_q[k]) cfg_d[k] = staging_q[k];
        end
        update_d = |dirty_q;
      end else if (state_q != ST_IDLE && !(state_q == ST_CMD && !edge_q)) begin
        staging_d = cfg_q;
        err_d     = 1'b1;
      end
    end

    // A fall seen together with a commit still opens the next frame after it.
    if (csn_fall) begin
      state_d = ST_CMD;
      cnt_d   = '0;
      addr_d  = '0;
      tx_d    = '0;
      miso_d  = 1'b0;
      words_d = 1'b0;
      edge_d  = 1'b0;
    end else if (!csn_rise && state_q != ST_IDLE) begin
      if (sck_rise || sck_fall) edge_d = 1'b1;
      if (sck_rise) begin
        unique case (state_q)
          ST_CMD: begin
            rw_d    = mosi_s2_q;
            cnt_d   = '0;
            state_d = ST_ADDR;
          end
          ST_ADDR: begin
            addr_d = addr_new;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ADDR_W - 1)) begin
              cnt_d   = '0;
              tx_d    = rd_new;
              state_d = ST_DATA;
            end
          end
          ST_DATA: begin
            rx_d  = word[DATA_W-2:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d   = '0;
              words_d = 1'b1;
              if (rw_q != RW_READ && wr_ok && 32'(addr_q) < NUM_REGS) begin
                staging_d[addr_q] = word;
                dirty_d[addr_q]   = 1'b1;
              end
`ifdef SPI_CFG_AUTOINC_EN
              addr_d = addr_inc;
              tx_d   = rd_inc;
`endif
            end
          end
          default: ;
        endcase
      end else if (sck_fall) begin
        if (state_q == ST_DATA) begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end else begin
          miso_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      words_q   <= 1'b0;
      edge_q    <= 1'b0;
      dirty_q   <= '0;
      update_q  <= 1'b0;
      err_q     <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        cfg_q[k]     <= RST_VALS[k*DATA_W +: DATA_W];
        staging_q[k] <= RST_VALS[k*DATA_W +: DATA_W];
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      words_q   <= words_d;
      edge_q    <= edge_d;
      dirty_q   <= dirty_d;
      update_q  <= update_d;
      err_q     <= err_d;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
      cfg_q     <= cfg_d;
      staging_q <= staging_d;
    end
  end

  always_comb begin
    cfg_flat = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      cfg_flat[k*DATA_W +: DATA_W] = cfg_q[k];
    end
  end

  assign spi_miso   = miso_q;
  assign cfg_update = update_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Directed bench for spi_cfg_regbank: table of SPI frames plus hand-written
// abort, no-op and mid-frame reset sequences. Honours SPI_CFG_AUTOINC_EN.
module tb_spi_cfg_regbank;

  localparam logic [47:0] RST  = 48'h0102_0304_0506;
  localparam int          HALF = 80;

`ifdef SPI_CFG_AUTOINC_EN
  localparam logic [47:0] F2   = 48'h0102_0333_2211;
  localparam logic [47:0] F3   = 48'h5A02_0333_2211;
  localparam logic [47:0] F4   = 48'h5A02_0333_2277;
  localparam logic [23:0] RD7  = 24'h001122;
  localparam logic [23:0] RD12 = 24'h000077;
  localparam int          U11  = 1;
`else
  localparam logic [47:0] F2   = 48'h0102_03A5_0511;
  localparam logic [47:0] F3   = 48'h5A02_03A5_0511;
  localparam logic [47:0] F4   = 48'h5A02_03A5_0511;
  localparam logic [23:0] RD7  = 24'h001100;
  localparam logic [23:0] RD12 = 24'h000011;
  localparam int          U11  = 0;
`endif
  localparam logic [47:0] F1 = 48'h0102_03A5_0506;

  typedef struct {
    logic        rw;
    logic [2:0]  addr;
    logic [23:0] data;
    int          nbits;
    logic [47:0] flat;
    int          upd;
    int          err;
    logic        chk_rd;
    logic [23:0] rd;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [47:0] cfg_flat;
  logic        cfg_update;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int err_cnt = 0;

  spi_cfg_regbank #(
    .ADDR_W(3), .DATA_W(8), .NUM_REGS(6), .RST_VALS(RST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_csn(spi_csn),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .cfg_flat(cfg_flat),
    .cfg_update(cfg_update), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_update) upd_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] bits, input int n, input bit raise,
                      output logic [31:0] rx, output logic [47:0] pre);
    rx = '0;
    spi_csn = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      #(HALF);
      spi_clk = 1'b1;
      rx = {rx[30:0], spi_miso};
      #(HALF);
      spi_clk = 1'b0;
    end
    #(HALF);
    pre = cfg_flat;
    if (raise) begin
      spi_csn = 1'b1;
      repeat (8) @(posedge clk);
      #2;
    end
  endtask

  initial begin
    logic [31:0] bits, rx, mask;
    logic [47:0] pre, f0;
    int u0, e0;

    vecs[0]  = '{1'b0, 3'd2, 24'hA5,     8,  F1,  1, 0, 1'b0, 24'h0};
    vecs[1]  = '{1'b1, 3'd2, 24'h0,      8,  F1,  0, 0, 1'b1, 24'hA5};
    vecs[2]  = '{1'b0, 3'd1, 24'h07,     5,  F1,  0, 1, 1'b0, 24'h0};
    vecs[3]  = '{1'b1, 3'd1, 24'h0,      8,  F1,  0, 0, 1'b1, 24'h05};
    vecs[4]  = '{1'b0, 3'd7, 24'hFF,     8,  F1,  0, 0, 1'b0, 24'h0};
    vecs[5]  = '{1'b1, 3'd7, 24'h0,      8,  F1,  0, 0, 1'b1, 24'h00};
    vecs[6]  = '{1'b0, 3'd0, 24'h112233, 24, F2,  1, 0, 1'b0, 24'h0};
    vecs[7]  = '{1'b1, 3'd0, 24'h0,      16, F2,  0, 0, 1'b1, RD7};
    vecs[8]  = '{1'b0, 3'd3, 24'hABC,    12, F2,  0, 1, 1'b0, 24'h0};
    vecs[9]  = '{1'b1, 3'd3, 24'h0,      8,  F2,  0, 0, 1'b1, 24'h03};
    vecs[10] = '{1'b0, 3'd5, 24'h5A,     8,  F3,  1, 0, 1'b0, 24'h0};
    vecs[11] = '{1'b0, 3'd7, 24'hEE77,   16, F4,  U11, 0, 1'b0, 24'h0};
    vecs[12] = '{1'b1, 3'd0, 24'h0,      8,  F4,  0, 0, 1'b1, RD12};

    repeat (3) @(posedge clk);
    #2;
    chk("reset_flat", 64'(cfg_flat), 64'(RST));
    chk("reset_miso", 64'(spi_miso), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("reset_pulses", 64'(upd_cnt + err_cnt), 64'd0);

    for (int v = 0; v < NV; v++) begin
      u0 = upd_cnt; e0 = err_cnt; f0 = cfg_flat;
      bits = ({31'b0, vecs[v].rw} << (vecs[v].nbits + 3)) |
             (32'(vecs[v].addr) << vecs[v].nbits) | 32'(vecs[v].data);
      xfer(bits, vecs[v].nbits + 4, 1'b1, rx, pre);
      chk($sformatf("v%0d_precommit", v), 64'(pre), 64'(f0));
      chk($sformatf("v%0d_flat", v), 64'(cfg_flat), 64'(vecs[v].flat));
      chk($sformatf("v%0d_update", v), 64'(upd_cnt - u0), 64'(vecs[v].upd));
      chk($sformatf("v%0d_err", v), 64'(err_cnt - e0), 64'(vecs[v].err));
      if (vecs[v].chk_rd) begin
        mask = (32'd1 << vecs[v].nbits) - 32'd1;
        chk($sformatf("v%0d_readback", v), 64'(rx & mask), 64'(vecs[v].rd));
      end
    end

    // CSn low/high with no SCK edges: nothing happens
    u0 = upd_cnt; e0 = err_cnt; f0 = cfg_flat;
    spi_csn = 1'b0;
    repeat (10) @(posedge clk);
    spi_csn = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("noop_pulses", 64'(upd_cnt - u0 + err_cnt - e0), 64'd0);
    chk("noop_flat", 64'(cfg_flat), 64'(f0));

    // Abort in CMD (only RW bit) and in ADDR (RW + 2 address bits)
    e0 = err_cnt;
    xfer(32'h1, 1, 1'b1, rx, pre);
    chk("cmd_abort_err", 64'(err_cnt - e0), 64'd1);
    e0 = err_cnt; u0 = upd_cnt;
    xfer(32'h2, 3, 1'b1, rx, pre);
    chk("addr_abort_err", 64'(err_cnt - e0), 64'd1);
    chk("addr_abort_upd", 64'(upd_cnt - u0), 64'd0);
    chk("abort_flat", 64'(cfg_flat), 64'(f0));

    // Reset asserted mid-write: immediate reset state, no pulses afterwards
    u0 = upd_cnt; e0 = err_cnt;
    xfer({20'b0, 1'b0, 3'd0, 8'hC3}, 10, 1'b0, rx, pre);
    rst_n = 1'b0;
    #3;
    chk("midrst_flat", 64'(cfg_flat), 64'(RST));
    chk("midrst_miso", 64'(spi_miso), 64'd0);
    spi_csn = 1'b1;
    spi_clk = 1'b0;
    repeat (4) @(posedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("midrst_pulses", 64'(upd_cnt - u0 + err_cnt - e0), 64'd0);
    chk("midrst_flat_after", 64'(cfg_flat), 64'(RST));
    xfer({24'b0, 1'b1, 3'd0, 8'h00}, 12, 1'b1, rx, pre);
    chk("midrst_read_reg0", 64'(rx & 32'hFF), 64'h06);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
